// File: rtl/score_pkg.sv
// Shared definitions for the score display.
//   conv_state_t : converter FSM states (IDLE, SHIFT, LOAD)
//   SEG_TABLE    : active-low 7-segment codes, index = BCD digit; 10..15 blank
//                  bit order {dp, g, f, e, d, c, b, a}, dp always off
//   SEG_BLANK    : all segments and dp off
//   pow10()      : elaboration-time power of ten, used for the clamp limit
package score_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } conv_state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [7:0] SEG_TABLE [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK,
    SEG_BLANK, SEG_BLANK
  };

  function automatic int unsigned pow10(input int n);
    int unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one bit per cycle.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : request a conversion of bin_in
//   bin_in       : binary value, captured on the accepted start
//   busy         : high from the cycle after start until the LOAD cycle ends
//   done         : high for exactly the LOAD cycle; bcd_out is final then
//   bcd_out      : NUM_DIGITS packed BCD nibbles, digit 0 in bits [3:0]
//   state        : FSM state, exported for debug/observation
//
// Handshake: start is accepted only in IDLE (busy low); bin_in is captured on
// that edge. Any start while busy is ignored. done is a one-cycle strobe that
// the consumer must take on the same edge; there is no back-pressure.
module bin2bcd_seq
  import score_pkg::*;
#(
  parameter int BIN_W      = 14,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [BIN_W-1:0]        bin_in,
  output logic                    busy,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output conv_state_t             state
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  conv_state_t             state_nxt;
  logic [BIN_W-1:0]        bin_q;
  logic [4*NUM_DIGITS-1:0] bcd_q;
  logic [4*NUM_DIGITS-1:0] bcd_adj;
  logic [CNT_W-1:0]        iter_q;
  logic                    last_iter;

  assign last_iter = (iter_q == CNT_W'(BIN_W - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_iter) state_nxt = LOAD;
      LOAD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Add-3 step: any nibble >= 5 would exceed 9 after doubling.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      bin_q  <= '0;
      bcd_q  <= '0;
      iter_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            bin_q  <= bin_in;
            bcd_q  <= '0;
            iter_q <= '0;
          end
        end
        SHIFT: begin
          // Top BCD bit is always zero because the value fits the digits.
          {bcd_q, bin_q} <= {bcd_adj[4*NUM_DIGITS-2:0], bin_q, 1'b0};
          iter_q         <= iter_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state != IDLE);
  assign done    = (state == LOAD);
  assign bcd_out = bcd_q;

endmodule

// File: rtl/score_bcd_display.sv
// Multiplexed 7-segment score display with sequential BCD conversion.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   enable       : 0 blanks the display and blocks new conversions
//   mode         : 1 shows lo_val, 0 shows hi_val*100 + lo_val
//   lo_val       : BIN_W-bit low value;  hi_val : HI_W-bit level value
//   seg          : active-low segments {dp, g..a}, registered
//   an           : active-low digit select, an[0] = rightmost, registered
//   busy         : conversion in progress
//   overflow     : committed value was clamped to 10^NUM_DIGITS-1
//   dbg_state    : converter FSM state for observation
// Build option: define SCORE_LZB_EN to blank leading zero digits (digit 0 is
// always shown).
module score_bcd_display
  import score_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W      = 14,
  parameter int HI_W       = 7,
  parameter int SCAN_DIV   = 100000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  mode,
  input  logic [BIN_W-1:0]      lo_val,
  input  logic [HI_W-1:0]       hi_val,
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  busy,
  output logic                  overflow,
  output conv_state_t           dbg_state
);

  // Wide enough for hi_val*100 (< 2^(HI_W+7)) plus lo_val without wrap.
  localparam int SUM_W = ((BIN_W > HI_W + 7) ? BIN_W : HI_W + 7) + 1;
  localparam logic [SUM_W-1:0] MAX_VAL = SUM_W'(pow10(NUM_DIGITS) - 1);
  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [SUM_W-1:0]        sum_val;
  logic                    clamp;
  logic [BIN_W-1:0]        target;
  logic [BIN_W-1:0]        last_value;
  logic                    last_ovf;
  logic                    start;
  logic                    conv_done;
  logic [4*NUM_DIGITS-1:0] bcd_w;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [PRE_W-1:0]        pre_cnt;
  logic [IDX_W-1:0]        idx;
  logic [3:0]              digit_cur;
  logic [NUM_DIGITS-1:0]   lead_zero;

  // Target value and clamp
  assign sum_val = mode ? SUM_W'(lo_val)
                        : SUM_W'(hi_val) * SUM_W'(100) + SUM_W'(lo_val);
  assign clamp   = (sum_val > MAX_VAL);
  assign target  = clamp ? MAX_VAL[BIN_W-1:0] : sum_val[BIN_W-1:0];

  // The clamp flag is part of the compare so that e.g. a true 9999 after a
  // clamped 9999 still reconverts and clears overflow.
  assign start = enable && (dbg_state == IDLE) &&
                 ({clamp, target} != {last_ovf, last_value});

  bin2bcd_seq #(
    .BIN_W      (BIN_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .bin_in  (target),
    .busy    (busy),
    .done    (conv_done),
    .bcd_out (bcd_w),
    .state   (dbg_state)
  );

  // Latched request and committed display digits. Digits only change on the
  // LOAD strobe, so a partially shifted value is never visible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_value <= '0;
      last_ovf   <= 1'b0;
      digits     <= '0;
      overflow   <= 1'b0;
    end else begin
      if (start) begin
        last_value <= target;
        last_ovf   <= clamp;
      end
      if (conv_done) begin
        digits   <= bcd_w;
        overflow <= last_ovf;
      end
    end
  end

  // Scan prescaler and digit index
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= '0;
      idx     <= '0;
    end else if (pre_cnt == PRE_W'(SCAN_DIV - 1)) begin
      pre_cnt <= '0;
      idx     <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  assign digit_cur = digits[{idx, 2'b00} +: 4];

`ifdef SCORE_LZB_EN
  // A digit is blanked when it and every digit above it are zero.
  always_comb begin
    logic zero_run;
    lead_zero = '0;
    zero_run  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run     = zero_run & (digits[4*i +: 4] == 4'd0);
      lead_zero[i] = zero_run;
    end
  end
`else
  assign lead_zero = '0;
`endif

  // Registered outputs, one cycle behind idx
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg <= SEG_BLANK;
      an  <= '1;
    end else if (!enable) begin
      seg <= SEG_BLANK;
      an  <= '1;
    end else begin
      an  <= ~(NUM_DIGITS'(1) << idx);
      seg <= lead_zero[idx] ? SEG_BLANK : SEG_TABLE[digit_cur];
    end
  end

endmodule
